// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers column/row from async VGA syncs and tracks line/frame lock.
// Sync inputs are sampled on pix_en ticks; outputs are registered one clk behind the counters.
module vga_sync_decoder #(
   parameter int H_TOTAL    = 800,
   parameter int H_PULSE    = 96,
   parameter int H_BP       = 48,
   parameter int H_ACTIVE   = 640,
   parameter int V_TOTAL    = 521,
   parameter int V_PULSE    = 2,
   parameter int V_BP       = 29,
   parameter int V_ACTIVE   = 480,
   parameter int H_TOL      = 1,
   parameter int LOCK_LINES = 4
) (
   input  logic       clk,
   input  logic       rst_l,
   input  logic       pix_en,
   input  logic       hsync_in,
   input  logic       vsync_in,
   output logic [9:0] col,
   output logic [8:0] row,
   output logic       active,
   output logic       locked,
   output logic       frame_start,
   output logic       sync_err
);
   typedef enum logic [1:0] {HUNT, VSEEK, LOCKED} state_e;

   localparam logic [10:0] L_MIN = 11'(H_TOTAL - H_TOL);
   localparam logic [10:0] L_MAX = 11'(H_TOTAL + H_TOL);
   localparam logic [10:0] H_LO  = 11'(H_PULSE + H_BP);
   localparam logic [10:0] H_HI  = 11'(H_PULSE + H_BP + H_ACTIVE);
   localparam logic [10:0] V_LO  = 11'(V_PULSE + V_BP);
   localparam logic [10:0] V_HI  = 11'(V_PULSE + V_BP + V_ACTIVE);
   localparam logic [9:0]  V_LIM = 10'(V_TOTAL + 1);
   localparam logic [9:0]  C_MAX = 10'h3ff;
   localparam logic [2:0]  G_LOCK = 3'(LOCK_LINES);

   state_e      state_q, state_d;
   logic [2:0]  gcnt_q, gcnt_d;
   logic [2:0]  hs_q, hs_d, vs_q, vs_d;
   logic [9:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d;
   logic        vpend_q, vpend_d;
   logic [9:0]  col_d;
   logic [8:0]  row_d;
   logic        active_q, active_d, fs_q, fs_d, se_q, se_d;
   logic [10:0] line_len;
   logic        hs_fall, vs_fall, line_good, good_line, bad_line, lost, h_in, v_in;

   // bit 0 is s1, bit 2 is s3; an edge is s3 high while s2 already low
   always_comb begin
      hs_d      = pix_en ? {hs_q[1:0], hsync_in} : hs_q;
      vs_d      = pix_en ? {vs_q[1:0], vsync_in} : vs_q;
      hs_fall   = pix_en & hs_q[2] & ~hs_q[1];
      vs_fall   = pix_en & vs_q[2] & ~vs_q[1];
      line_len  = {1'b0, hcnt_q} + 11'd1;
      line_good = (line_len >= L_MIN) && (line_len <= L_MAX);
      good_line = hs_fall & line_good;
      bad_line  = hs_fall & ~line_good;
      hcnt_d    = ~pix_en ? hcnt_q : hs_fall ? 10'd0 : (hcnt_q == C_MAX) ? hcnt_q : hcnt_q + 10'd1;
      vcnt_d    = ~hs_fall ? vcnt_q : (vpend_q | vs_fall) ? 10'd0 :
                  (vcnt_q == C_MAX) ? vcnt_q : vcnt_q + 10'd1;
      vpend_d   = hs_fall ? 1'b0 : (vs_fall | vpend_q);
      lost      = (state_q == LOCKED) &
                  (bad_line | (pix_en & (hcnt_d == C_MAX)) | (hs_fall & (vcnt_d == V_LIM)));
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q <= HUNT;
         gcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         gcnt_q  <= gcnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      gcnt_d  = gcnt_q;
      unique case (state_q)
         HUNT: begin
            if (bad_line) gcnt_d = '0;
            else if (good_line) begin
               gcnt_d  = (gcnt_q + 3'd1 == G_LOCK) ? 3'd0 : gcnt_q + 3'd1;
               state_d = (gcnt_q + 3'd1 == G_LOCK) ? VSEEK : HUNT;
            end
         end
         VSEEK: begin
            if (bad_line) state_d = HUNT;
            else if (vs_fall) state_d = LOCKED;
         end
         LOCKED: begin
            if (lost) begin
               state_d = HUNT;
               gcnt_d  = '0;
            end
         end
         default: begin
            state_d = HUNT;
            gcnt_d  = '0;
         end
      endcase
   end

   // loss of lock wins over a coincident vsync edge
   always_comb begin
      fs_d     = vs_fall & (((state_q == VSEEK) & ~bad_line) | ((state_q == LOCKED) & ~lost));
      se_d     = lost;
      h_in     = ({1'b0, hcnt_q} >= H_LO) && ({1'b0, hcnt_q} < H_HI);
      v_in     = ({1'b0, vcnt_q} >= V_LO) && ({1'b0, vcnt_q} < V_HI);
      col_d    = h_in ? hcnt_q - H_LO[9:0] : '0;
      row_d    = v_in ? 9'(vcnt_q - V_LO[9:0]) : '0;
      active_d = h_in & v_in & (state_q == LOCKED);
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         hs_q     <= '1;
         vs_q     <= '1;
         hcnt_q   <= '0;
         vcnt_q   <= '0;
         vpend_q  <= 1'b0;
         col      <= '0;
         row      <= '0;
         active_q <= 1'b0;
         fs_q     <= 1'b0;
         se_q     <= 1'b0;
      end else begin
         hs_q     <= hs_d;
         vs_q     <= vs_d;
         hcnt_q   <= hcnt_d;
         vcnt_q   <= vcnt_d;
         vpend_q  <= vpend_d;
         col      <= col_d;
         row      <= row_d;
         active_q <= active_d;
         fs_q     <= fs_d;
         se_q     <= se_d;
      end
   end

   assign active      = active_q;
   assign locked      = (state_q == LOCKED);
   assign frame_start = fs_q;
   assign sync_err    = se_q;
endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: directed checks of lock, mapping, loss and reset on a reduced raster.
// Raster is 40x12 ticks so whole frames fit in a short run.
module tb_vga_sync_decoder;
   localparam int HT = 40, HP = 4, HB = 4, HA = 24;
   localparam int VT = 12, VP = 1, VB = 2, VA = 6;

   logic       clk = 1'b0, rst_l = 1'b0, pix_en = 1'b0, hsync_in = 1'b1, vsync_in = 1'b1;
   logic [9:0] col;
   logic [8:0] row;
   logic       active, locked, frame_start, sync_err;
   int         checks = 0, errors = 0, div = 2, map_err = 0;
   int         fs_cnt = 0, se_cnt = 0, act_cnt = 0, pulse_bad = 0;
   int         fs0, se0, act0;
   logic       fs_prev = 1'b0, se_prev = 1'b0, se_act = 1'b1;
   logic [9:0] se_col = '1;

   typedef struct {int len; int exp_err; bit exp_lock;} vec_t;
   vec_t vecs[6];

   always #5 clk = ~clk;

   vga_sync_decoder #(
      .H_TOTAL(HT), .H_PULSE(HP), .H_BP(HB), .H_ACTIVE(HA),
      .V_TOTAL(VT), .V_PULSE(VP), .V_BP(VB), .V_ACTIVE(VA),
      .H_TOL(1), .LOCK_LINES(4)
   ) dut (
      .clk(clk), .rst_l(rst_l), .pix_en(pix_en), .hsync_in(hsync_in), .vsync_in(vsync_in),
      .col(col), .row(row), .active(active), .locked(locked),
      .frame_start(frame_start), .sync_err(sync_err)
   );

   always @(negedge clk) begin
      fs_prev <= frame_start;
      se_prev <= sync_err;
      if (frame_start) fs_cnt <= fs_cnt + 1;
      if (sync_err) begin
         se_cnt <= se_cnt + 1;
         se_col <= col;
         se_act <= active;
      end
      if (active) act_cnt <= act_cnt + 1;
      if ((frame_start && sync_err) || (frame_start && fs_prev) || (sync_err && se_prev))
         pulse_bad <= pulse_bad + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: run exceeded its time bound");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick(input logic hs, input logic vs);
      hsync_in = hs;
      vsync_in = vs;
      pix_en   = 1'b1;
      @(negedge clk);
      pix_en = 1'b0;
      repeat (div - 1) @(negedge clk);
   endtask

   // with div >= 2 the outputs seen after a tick reflect the counters that tick produced
   task automatic line(input int ln, input int len, input bit vs_en, input bit chk);
      for (int t = 0; t < len; t++) begin
         tick((t < HP) ? 1'b0 : 1'b1, (vs_en && ln < VP) ? 1'b0 : 1'b1);
         if (chk) begin
            int hh, vv, ec, er;
            bit hw, vw;
            hh = (t >= 2) ? t - 2 : HT + t - 2;
            vv = (t >= 2) ? ln : ((ln == 0) ? VT - 1 : ln - 1);
            hw = (hh >= HP + HB) && (hh < HP + HB + HA);
            vw = (vv >= VP + VB) && (vv < VP + VB + VA);
            ec = hw ? hh - HP - HB : 0;
            er = vw ? vv - VP - VB : 0;
            if (col !== ec[9:0] || row !== er[8:0] || active !== (hw && vw)) map_err++;
         end
      end
   endtask

   task automatic frame(input int first, input int last, input bit vs_en, input bit chk);
      for (int l = first; l <= last; l++) line(l, HT, vs_en, chk);
   endtask

   task automatic do_reset();
      hsync_in = 1'b1;
      vsync_in = 1'b1;
      rst_l    = 1'b0;
      repeat (3) @(negedge clk);
      rst_l = 1'b1;
   endtask

   task automatic acquire();
      do_reset();
      frame(0, VT - 1, 1'b1, 1'b0);
      frame(0, 4, 1'b1, 1'b0);
   endtask

   initial begin
      vecs[0] = '{40, 0, 1'b1};
      vecs[1] = '{39, 0, 1'b1};
      vecs[2] = '{41, 0, 1'b1};
      vecs[3] = '{38, 1, 1'b0};
      vecs[4] = '{42, 1, 1'b0};
      vecs[5] = '{30, 1, 1'b0};

      repeat (3) @(negedge clk);
      check("reset_outputs", {col, row, active, locked, frame_start, sync_err}, 0);
      rst_l = 1'b1;

      div = 4;
      frame(0, VT - 1, 1'b1, 1'b0);
      check("vseek_unlocked", locked, 0);
      fs0 = fs_cnt; se0 = se_cnt; act0 = act_cnt;
      for (int f = 1; f <= 3; f++) begin
         map_err = 0;
         frame(0, VT - 1, 1'b1, 1'b1);
         check($sformatf("map_frame%0d", f), map_err, 0);
      end
      check("nominal_locked", locked, 1);
      check("nominal_frame_starts", fs_cnt - fs0, 3);
      check("nominal_sync_err", se_cnt - se0, 0);
      check("nominal_active_clks", act_cnt - act0, 3 * HA * VA * 4);

      div = 2;
      foreach (vecs[i]) begin
         acquire();
         check($sformatf("len%0d_prelock", vecs[i].len), locked, 1);
         se0 = se_cnt;
         line(5, vecs[i].len, 1'b1, 1'b0);
         line(6, HT, 1'b1, 1'b0);
         check($sformatf("len%0d_sync_err", vecs[i].len), se_cnt - se0, vecs[i].exp_err);
         check($sformatf("len%0d_locked", vecs[i].len), locked, vecs[i].exp_lock);
      end

      div = 1;
      acquire();
      se0 = se_cnt; fs0 = fs_cnt;
      line(5, 30, 1'b1, 1'b0);
      line(6, HT, 1'b1, 1'b0);
      check("short_sync_err", se_cnt - se0, 1);
      check("short_unlocked", locked, 0);
      frame(7, VT - 1, 1'b1, 1'b0);
      line(0, HT, 1'b1, 1'b0);
      check("relock_locked", locked, 1);
      check("relock_frame_start", fs_cnt - fs0, 1);

      div = 2;
      acquire();
      se0 = se_cnt;
      for (int k = 0; k < 1100; k++) tick(1'b1, 1'b1);
      check("stuck_sync_err", se_cnt - se0, 1);
      check("stuck_unlocked", locked, 0);
      check("stuck_col_at_err", se_col, 0);
      check("stuck_active_at_err", se_act, 0);

      acquire();
      frame(5, VT - 1, 1'b1, 1'b0);
      se0 = se_cnt;
      line(0, HT, 1'b0, 1'b0);
      check("novs_line12_err", se_cnt - se0, 0);
      check("novs_line12_locked", locked, 1);
      line(1, HT, 1'b0, 1'b0);
      check("novs_line13_err", se_cnt - se0, 1);
      check("novs_line13_locked", locked, 0);

      acquire();
      line(5, 15, 1'b1, 1'b0);
      check("midframe_active", active, 1);
      check("midframe_row", row, 2);
      #2 rst_l = 1'b0;
      #1 check("async_reset_outputs", {col, row, active, locked, frame_start, sync_err}, 0);
      repeat (2) @(negedge clk);
      rst_l = 1'b1;
      fs0 = fs_cnt;
      frame(0, VT - 1, 1'b1, 1'b0);
      check("post_reset_unlocked", locked, 0);
      line(0, HT, 1'b1, 1'b0);
      check("post_reset_relock", locked, 1);
      check("post_reset_frame_start", fs_cnt - fs0, 1);

      check("pulse_rules", pulse_bad, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 Parameter H_TOTAL, default 800, pixel ticks per line.
REQ-002 Parameter H_PULSE, default 96, nominal hsync low width in ticks.
REQ-003 Parameter H_BP, default 48, back porch ticks after hsync pulse.
REQ-004 Parameter H_ACTIVE, default 640, visible ticks per line.
REQ-005 Parameter V_TOTAL, default 521, lines per frame; V_PULSE, default 2; V_BP, default 29; V_ACTIVE, default 480.
REQ-006 Parameter H_TOL, default 1, allowed +/- ticks of line-length error; LOCK_LINES, default 4, consecutive good lines required for line lock.
REQ-007 Port clk  in  1  system clock; one clock; all flops on its rising edge.
REQ-008 Port rst_l  in  1  reset, asynchronous assert, active-low.
REQ-009 Port pix_en  in  1  pixel-tick enable; all state below advances only on clk cycles with pix_en=1.
REQ-010 Port hsync_in / vsync_in  in  1 each  asynchronous sync inputs, active-low pulses.
REQ-011 Port col  out  10  recovered column; row  out  9  recovered row.
REQ-012 Port active  out  1  high while (row,col) lies in the visible window and locked=1.
REQ-013 Port locked  out  1  high in state LOCKED.
REQ-014 Port frame_start  out  1  one-clk pulse at each accepted vsync falling edge.
REQ-015 Port sync_err  out  1  one-clk pulse when lock is lost.

Function
REQ-016 Each sync input SHALL pass through three flops (s1,s2,s3) advancing on pix_en ticks; falling edge = s3 & ~s2.
REQ-017 hcnt (10 bit) SHALL load 0 on an hsync falling edge, else increment per tick, saturating at 1023.
REQ-018 At each hsync falling edge the line length L = hcnt+1 SHALL be "good" iff H_TOTAL-H_TOL <= L <= H_TOTAL+H_TOL.
REQ-019 A vsync falling edge SHALL set vpend; on the next hsync falling edge vcnt SHALL load 0 and vpend clear; otherwise vcnt increments per hsync falling edge, saturating at 1023.
REQ-020 Simultaneous hsync and vsync falling edges SHALL load vcnt 0 on that same tick.
REQ-021 col SHALL equal hcnt-(H_PULSE+H_BP) when H_PULSE+H_BP <= hcnt < H_PULSE+H_BP+H_ACTIVE, else 0; row likewise from vcnt with V_PULSE+V_BP, V_ACTIVE; both truncated to port width.
REQ-022 active SHALL be high iff both windows of REQ-021 hold and locked=1; col, row, active SHALL be registered outputs of the same tick.
REQ-023 FSM states HUNT, VSEEK, LOCKED; good-line counter gcnt (3 bit).
REQ-024 HUNT: each good line increments gcnt; bad line clears gcnt; gcnt reaching LOCK_LINES SHALL move to VSEEK and clear gcnt.
REQ-025 VSEEK: vsync falling edge SHALL move to LOCKED and pulse frame_start; bad line SHALL return to HUNT without sync_err.
REQ-026 LOCKED: vsync falling edge pulses frame_start; a bad line, hcnt reaching 1023, or vcnt reaching V_TOTAL+1 without vsync SHALL move to HUNT, clear gcnt, and pulse sync_err.
REQ-027 frame_start and sync_err SHALL never assert in the same cycle; loss of lock takes priority.
REQ-028 frame_start and sync_err SHALL last exactly one clk even when pix_en is held high across consecutive cycles.
REQ-029 Latency: an input edge SHALL affect hcnt/vcnt three pix_en ticks after it is presented, and the outputs on the following clk.

Reset
REQ-030 While rst_l=0: state HUNT; hcnt, vcnt, gcnt, vpend 0; sync flops 1; col 0; row 0; active 0; locked 0; frame_start 0; sync_err 0.
REQ-031 Reset asserted mid-frame SHALL drop locked and active immediately (asynchronously) and require full reacquisition after release.

Verification
REQ-032 Nominal 800x521 timing, pix_en every 4th clk, 3 frames -> locked=1 by line 5 + first vsync; frame_start once per frame; active high for exactly 640x480 ticks per frame.
REQ-033 In LOCKED, one line shortened to 790 ticks -> sync_err single pulse, locked=0, state HUNT; reacquires after 4 good lines + vsync.
REQ-034 Lines of 799 and 801 ticks with H_TOL=1 -> treated good, no sync_err; 798 -> bad.
REQ-035 hsync held high 1100 ticks while LOCKED -> sync_err at hcnt=1023, col=0, active=0.
REQ-036 vsync and hsync falling on same tick -> vcnt=0 that tick; first visible row=0 at line 31, col=0 at hcnt=144.
REQ-037 rst_l pulsed low mid-frame -> all outputs 0 asynchronously; relock after reset release as in REQ-032.
